// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared constants, state/error enums and LFSR step for the maze stream host
package maze_pkg;

  localparam int DIM   = 15;
  localparam int CELLS = DIM * DIM;

  localparam logic [3:0] START_X = 4'd1;
  localparam logic [3:0] START_Y = 4'd1;
  localparam logic [3:0] GOAL_X  = 4'd13;
  localparam logic [3:0] GOAL_Y  = 4'd13;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    CHECK,
    FINISH
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_START,
    ERR_WALL,
    ERR_STEP,
    ERR_END,
    ERR_UNSOLV,
    ERR_PROTO,
    ERR_TIMEOUT
  } err_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// rtl/maze_lfsr.sv - 16-bit Galois LFSR with load/step, exposes the low OUT_W bits as value
module maze_lfsr
  import maze_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [15:0]      seed,
  output logic [OUT_W-1:0] value
);

  logic [15:0] state_q;

  // load together with step lets the first draw come straight from the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_DEFAULT;
    end else if (load) begin
      state_q <= step ? lfsr_next(seed) : seed;
    end else if (step) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/maze_stream_host.sv
// rtl/maze_stream_host.sv - maze generator/streamer and solver-answer checker; option MAZE_HOST_TIMEOUT_EN
module maze_stream_host
  import maze_pkg::*;
#(
  parameter int WALL_PCT = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic        force_path,
  output logic        maze,
  output logic        in_valid,
  input  logic        sol_valid,
  input  logic        sol_not_valid,
  input  logic [3:0]  sol_x,
  input  logic [3:0]  sol_y,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err,
  output logic [7:0]  path_len
);

  localparam logic [3:0] EDGE_HI  = 4'(DIM - 1);
  localparam logic [3:0] DIM4     = 4'(DIM);
  localparam logic [7:0] DIM8     = 8'(DIM);
  localparam logic [4:0] WALL_LIM = 5'(WALL_PCT);

  state_e           state, state_nx;
  err_e             err_q, err_nx, beat_err;
  logic             start_ok, send_bit, beat, tmo_hit;
  logic [15:0]      seed_eff;
  logic [3:0]       lfsr_rnd, gen_rnd, gx, gy, bx, by, px, py, adx, ady;
  logic             gen_force, gen_bit, force_q;
  logic [CELLS-1:0] store;
  logic [7:0]       cell_idx, len_q;
  logic             cell_wall, maze_q, in_valid_q, done_q, pass_q;

  assign start_ok = (state == IDLE) && start;
  assign seed_eff = (seed == 16'h0000) ? SEED_DEFAULT : seed;

  maze_lfsr #(.OUT_W(4)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .step  (send_bit),
    .seed  (seed_eff),
    .value (lfsr_rnd)
  );

  // Cell (0,0) is produced in the start cycle so in_valid can rise on the next edge
  assign gx        = start_ok ? 4'd0 : bx;
  assign gy        = start_ok ? 4'd0 : by;
  assign gen_rnd   = start_ok ? seed_eff[3:0] : lfsr_rnd;
  assign gen_force = start_ok ? force_path : force_q;

  always_comb begin
    gen_bit = ({1'b0, gen_rnd} < WALL_LIM);
    if (gx == 4'd0 || gy == 4'd0 || gx == EDGE_HI || gy == EDGE_HI) begin
      gen_bit = 1'b1;
    end else if ((gx == START_X && gy == START_Y) || (gx == GOAL_X && gy == GOAL_Y)) begin
      gen_bit = 1'b0;
    end else if (gen_force && (gy == START_Y || gx == GOAL_X)) begin
      gen_bit = 1'b0;
    end
  end

  assign cell_idx = {4'd0, sol_y} * DIM8 + {4'd0, sol_x};
  assign adx      = (sol_x > px) ? (sol_x - px) : (px - sol_x);
  assign ady      = (sol_y > py) ? (sol_y - py) : (py - sol_y);

  always_comb begin
    cell_wall = 1'b1;
    if (sol_x < DIM4 && sol_y < DIM4) begin
      cell_wall = store[cell_idx];
    end
    beat_err = ERR_NONE;
    if (len_q == 8'd0) begin
      if (sol_x != START_X || sol_y != START_Y) begin
        beat_err = ERR_START;
      end
    end else if (cell_wall) begin
      beat_err = ERR_WALL;
    end else if (({1'b0, adx} + {1'b0, ady}) != 5'd1) begin
      beat_err = ERR_STEP;
    end
  end

`ifdef MAZE_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == WAIT && !sol_valid && !sol_not_valid) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    send_bit = 1'b0;
    beat     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEND;
          err_nx   = ERR_NONE;
          send_bit = 1'b1;
        end
      end
      SEND: begin
        if (sol_valid || sol_not_valid) begin
          state_nx = FINISH;
          err_nx   = ERR_PROTO;
        end else if (by == DIM4) begin
          state_nx = WAIT;
        end else begin
          send_bit = 1'b1;
        end
      end
      WAIT: begin
        if (sol_valid && sol_not_valid) begin
          state_nx = FINISH;
          err_nx   = ERR_PROTO;
        end else if (sol_valid) begin
          state_nx = CHECK;
          beat     = 1'b1;
        end else if (sol_not_valid) begin
          state_nx = FINISH;
          err_nx   = force_q ? ERR_UNSOLV : ERR_NONE;
        end else if (tmo_hit) begin
          state_nx = FINISH;
          err_nx   = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (sol_valid && sol_not_valid) begin
          state_nx = FINISH;
          if (err_q == ERR_NONE) err_nx = ERR_PROTO;
        end else if (sol_valid) begin
          beat = 1'b1;
        end else begin
          state_nx = FINISH;
          if (err_q == ERR_NONE && (px != GOAL_X || py != GOAL_Y)) err_nx = ERR_END;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Only the first failing beat is recorded
    if (beat && err_q == ERR_NONE) err_nx = beat_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= ERR_NONE;
      force_q    <= 1'b0;
      bx         <= '0;
      by         <= '0;
      px         <= '0;
      py         <= '0;
      store      <= '0;
      len_q      <= '0;
      maze_q     <= 1'b0;
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      err_q      <= err_nx;
      in_valid_q <= send_bit;
      maze_q     <= send_bit & gen_bit;
      done_q     <= (state == FINISH);
      if (state == FINISH) pass_q <= (err_q == ERR_NONE);
      if (start_ok) begin
        force_q <= force_path;
        pass_q  <= 1'b0;
        len_q   <= '0;
        px      <= '0;
        py      <= '0;
      end
      // Shifting in from the top leaves cell i at store[i] once all cells are sent
      if (send_bit) begin
        store <= {gen_bit, store[CELLS-1:1]};
        if (gx == EDGE_HI) begin
          bx <= '0;
          by <= gy + 4'd1;
        end else begin
          bx <= gx + 4'd1;
          by <= gy;
        end
      end
      if (beat) begin
        px <= sol_x;
        py <= sol_y;
        if (len_q != 8'hFF) len_q <= len_q + 8'd1;
      end
    end
  end

  assign maze     = maze_q;
  assign in_valid = in_valid_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err      = err_q;
  assign path_len = len_q;

endmodule

// File: tb/tb_maze_stream_host.sv
// tb/tb_maze_stream_host.sv - directed bench for maze_stream_host with a maze-stream model
module tb_maze_stream_host;

  localparam int CELLS    = 225;
  localparam int WALL_PCT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        force_path = 1'b0;
  logic        maze, in_valid;
  logic        sol_valid = 1'b0;
  logic        sol_not_valid = 1'b0;
  logic [3:0]  sol_x = 4'd0;
  logic [3:0]  sol_y = 4'd0;
  logic        done, pass;
  logic [2:0]  err;
  logic [7:0]  path_len;

  int   vectors = 0;
  int   errors = 0;
  logic exp_maze [CELLS];
  logic capt [CELLS];
  bit   mon_en = 1'b0;
  int   mon_k = 0;
  logic [7:0] path [$];

  always #5 clk = ~clk;

  maze_stream_host dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .seed          (seed),
    .force_path    (force_path),
    .maze          (maze),
    .in_valid      (in_valid),
    .sol_valid     (sol_valid),
    .sol_not_valid (sol_not_valid),
    .sol_x         (sol_x),
    .sol_y         (sol_y),
    .done          (done),
    .pass          (pass),
    .err           (err),
    .path_len      (path_len)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Maze from the rules: borders wall, start/goal open, forced route open, else lfsr[3:0] < WALL_PCT
  task automatic build_model(input logic [15:0] s, input logic f);
    logic [15:0] r;
    logic w;
    r = (s == 16'h0) ? 16'hACE1 : s;
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < 15; x++) begin
        if (x == 0 || y == 0 || x == 14 || y == 14) w = 1'b1;
        else if ((x == 1 && y == 1) || (x == 13 && y == 13)) w = 1'b0;
        else if (f && (y == 1 || x == 13)) w = 1'b0;
        else w = (int'(r[3:0]) < WALL_PCT);
        exp_maze[y*15 + x] = w;
        r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && in_valid) begin
      if (mon_k < CELLS) begin
        check($sformatf("maze_bit[%0d]", mon_k), 32'(maze), 32'(exp_maze[mon_k]));
        capt[mon_k] = maze;
      end else begin
        check("stream_overrun", 32'(mon_k), 32'(CELLS - 1));
      end
      mon_k++;
    end
  end

  task automatic begin_run(input logic [15:0] s, input logic f);
    build_model(s, f);
    mon_k  = 0;
    mon_en = 1'b1;
    seed = s;
    force_path = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed = 16'h0;
    force_path = 1'b0;
    check("in_valid_rise", 32'(in_valid), 32'd1);
  endtask

  task automatic finish_stream(input bit poke);
    int n;
    int guard;
    n = 1;
    guard = 0;
    while (in_valid && guard < 400) begin
      @(negedge clk);
      guard++;
      start = (poke && guard == 50);
      seed  = (poke && guard == 50) ? 16'hFFFF : 16'h0;
      if (in_valid) n++;
    end
    start = 1'b0;
    check("in_valid_cycles", 32'(n), 32'(CELLS));
    mon_en = 1'b0;
  endtask

  task automatic send_path();
    repeat (3) @(negedge clk);
    foreach (path[i]) begin
      sol_valid = 1'b1;
      sol_x = path[i][7:4];
      sol_y = path[i][3:0];
      @(negedge clk);
    end
    sol_valid = 1'b0;
    sol_x = 4'd0;
    sol_y = 4'd0;
  endtask

  task automatic pulse_not_valid();
    repeat (3) @(negedge clk);
    sol_not_valid = 1'b1;
    @(negedge clk);
    sol_not_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic exp_pass, input logic [2:0] exp_err,
                             input logic [7:0] exp_len);
    int g;
    g = 0;
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    check({tag, ":done"}, 32'(done), 32'd1);
    check({tag, ":pass"}, 32'(pass), 32'(exp_pass));
    check({tag, ":err"}, 32'(err), 32'(exp_err));
    check({tag, ":path_len"}, 32'(path_len), 32'(exp_len));
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
    check({tag, ":pass_held"}, 32'(pass), 32'(exp_pass));
  endtask

  // Row 1 from x=1 to 13, then column 13 down to y=13: open whenever force_path=1
  task automatic route(input int x_first, input int skip_x, input int y_last);
    path.delete();
    for (int x = x_first; x <= 13; x++) if (x != skip_x) path.push_back({x[3:0], 4'd1});
    for (int y = 2; y <= y_last; y++) path.push_back({4'd13, y[3:0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_maze", 32'(maze), 32'd0);
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_path_len", 32'(path_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal route; a second start mid-stream must be ignored
    begin_run(16'h1234, 1'b1);
    finish_stream(1'b1);
    check("pin_corner", 32'(capt[0]), 32'd1);
    check("pin_start", 32'(capt[16]), 32'd0);
    check("pin_row1", 32'(capt[20]), 32'd0);
    check("pin_col13", 32'(capt[88]), 32'd0);
    check("pin_goal", 32'(capt[208]), 32'd0);
    check("pin_last", 32'(capt[224]), 32'd1);
    route(1, -1, 13);
    send_path();
    expect_done("ideal", 1'b1, 3'd0, 8'd25);

    // seed 1 walked by hand: states after 17/18/19 steps are 8A20, 4510, 2288
    begin_run(16'h0001, 1'b0);
    finish_stream(1'b0);
    check("pin_s1_17", 32'(capt[17]), 32'd1);
    check("pin_s1_18", 32'(capt[18]), 32'd1);
    check("pin_s1_19", 32'(capt[19]), 32'd0);
    pulse_not_valid();
    expect_done("unsolv_free", 1'b1, 3'd0, 8'd0);

    begin_run(16'h1234, 1'b1);
    finish_stream(1'b0);
    route(2, -1, 13);
    send_path();
    expect_done("bad_start", 1'b0, 3'd1, 8'd24);

    begin_run(16'h1234, 1'b1);
    finish_stream(1'b0);
    route(1, 6, 13);
    send_path();
    expect_done("jump", 1'b0, 3'd3, 8'd24);

    begin_run(16'h4321, 1'b1);
    finish_stream(1'b0);
    route(1, -1, 12);
    send_path();
    expect_done("short", 1'b0, 3'd4, 8'd24);

    begin_run(16'h4321, 1'b1);
    finish_stream(1'b0);
    path.delete();
    path.push_back(8'h11);
    path.push_back(8'h01);
    send_path();
    expect_done("wall", 1'b0, 3'd2, 8'd2);

    // 300 legal beats bouncing between (1,1) and (2,1): length saturates, end is wrong
    begin_run(16'h00FF, 1'b1);
    finish_stream(1'b0);
    path.delete();
    for (int i = 0; i < 300; i++) path.push_back((i % 2 == 0) ? 8'h11 : 8'h21);
    send_path();
    expect_done("saturate", 1'b0, 3'd4, 8'd255);

    // zero seed falls back to ACE1
    begin_run(16'h0000, 1'b1);
    finish_stream(1'b0);
    pulse_not_valid();
    expect_done("unsolv_forced", 1'b0, 3'd5, 8'd0);

    // solver talks during SEND cycle 100
    begin_run(16'h1234, 1'b1);
    repeat (99) @(negedge clk);
    sol_valid = 1'b1;
    sol_x = 4'd1;
    sol_y = 4'd1;
    @(negedge clk);
    sol_valid = 1'b0;
    check("proto_in_valid_drop", 32'(in_valid), 32'd0);
    check("proto_bits_sent", 32'(mon_k), 32'd100);
    mon_en = 1'b0;
    expect_done("proto", 1'b0, 3'd6, 8'd0);

    // asynchronous reset mid-SEND
    begin_run(16'h5555, 1'b0);
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_valid", 32'(in_valid), 32'd0);
    check("midrst_maze", 32'(maze), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || in_valid) n++;
    end
    check("midrst_quiet", 32'(n), 32'd0);

`ifdef MAZE_HOST_TIMEOUT_EN
    begin_run(16'h1234, 1'b1);
    finish_stream(1'b0);
    n = 0;
    while (!done && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd1024);
    check("timeout_err", 32'(err), 32'd7);
    check("timeout_pass", 32'(pass), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
